// File: rtl/sram_like_arbiter_pkg.sv
// rtl/sram_like_arbiter_pkg.sv - shared encodings for the sram-like port arbiter
package sram_like_arbiter_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_D = 2'd1,
        LOCK_I = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// rtl/sram_like_arbiter_owner_fifo.sv - 1-bit in-order owner FIFO for accepted transactions
module owner_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic             din,
    output logic             dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally; count alone tells full from empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - shares one sram-like port between inst and data requesters
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inst_req,
    input  logic             inst_wr,
    input  logic [1:0]       inst_size,
    input  logic [3:0]       inst_wstrb,
    input  logic [31:0]      inst_addr,
    input  logic [31:0]      inst_wdata,
    output logic             inst_addr_ok,
    output logic             inst_data_ok,
    output logic [31:0]      inst_rdata,
    input  logic             data_req,
    input  logic             data_wr,
    input  logic [1:0]       data_size,
    input  logic [3:0]       data_wstrb,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_wdata,
    output logic             data_addr_ok,
    output logic             data_data_ok,
    output logic [31:0]      data_rdata,
    output logic             m_req,
    output logic             m_wr,
    output logic [1:0]       m_size,
    output logic [3:0]       m_wstrb,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wdata,
    input  logic             m_addr_ok,
    input  logic             m_data_ok,
    input  logic [31:0]      m_rdata,
    output logic [CNT_W-1:0] outst_cnt,
    output logic             proto_err
);

    arb_state_t state, state_nxt;
    logic       sel_data, sel_inst, req_ok;
    logic       accept, pop, head, full, empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Locked states keep the owner on the bus even if the other side requests.
    always_comb begin
        state_nxt = state;
        sel_data  = 1'b0;
        sel_inst  = 1'b0;
        req_ok    = 1'b0;
        case (state)
            IDLE: begin
                if (!full) begin
                    if (data_req) begin
                        sel_data = 1'b1;
                        req_ok   = 1'b1;
                        if (!m_addr_ok) state_nxt = LOCK_D;
                    end else if (inst_req) begin
                        sel_inst = 1'b1;
                        req_ok   = 1'b1;
                        if (!m_addr_ok) state_nxt = LOCK_I;
                    end
                end
            end
            LOCK_D: begin
                sel_data = 1'b1;
                if (!data_req) begin
                    state_nxt = IDLE;
                end else if (!full) begin
                    req_ok = 1'b1;
                    if (m_addr_ok) state_nxt = IDLE;
                end
            end
            LOCK_I: begin
                sel_inst = 1'b1;
                if (!inst_req) begin
                    state_nxt = IDLE;
                end else if (!full) begin
                    req_ok = 1'b1;
                    if (m_addr_ok) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_wr    = 1'b0;
        m_size  = '0;
        m_wstrb = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (resetn && sel_data) begin
            m_wr    = data_wr;
            m_size  = data_size;
            m_wstrb = data_wstrb;
            m_addr  = data_addr;
            m_wdata = data_wdata;
        end else if (resetn && sel_inst) begin
            m_wr    = inst_wr;
            m_size  = inst_size;
            m_wstrb = inst_wstrb;
            m_addr  = inst_addr;
            m_wdata = inst_wdata;
        end
    end

    assign m_req        = resetn & req_ok;
    assign accept       = m_req & m_addr_ok;
    assign data_addr_ok = accept & sel_data;
    assign inst_addr_ok = accept & sel_inst;

    owner_fifo #(
        .DEPTH (MAX_OUTST),
        .CNT_W (CNT_W)
    ) u_owner_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (pop),
        .din    (sel_data ? OWN_DATA : OWN_INST),
        .dout   (head),
        .count  (outst_cnt),
        .full   (full),
        .empty  (empty)
    );

    assign pop          = resetn & m_data_ok & ~empty;
    assign data_data_ok = pop & (head == OWN_DATA);
    assign inst_data_ok = pop & (head == OWN_INST);
    assign data_rdata   = data_data_ok ? m_rdata : '0;
    assign inst_rdata   = inst_data_ok ? m_rdata : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            proto_err <= 1'b0;
        end else if (m_data_ok && empty) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - directed self-checking bench for sram_like_arbiter
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, m_size;
    logic [3:0]  inst_wstrb, data_wstrb, m_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        m_req, m_wr, m_addr_ok, m_data_ok;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [2:0]  outst_cnt;
    logic        proto_err;

    int n_pass  = 0;
    int n_total = 0;

    sram_like_arbiter #(.MAX_OUTST(4), .CNT_W(3)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_size       (m_size),
        .m_wstrb      (m_wstrb),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_addr_ok    (m_addr_ok),
        .m_data_ok    (m_data_ok),
        .m_rdata      (m_rdata),
        .outst_cnt    (outst_cnt),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // One response beat; the named requester must see it, the other must not.
    task automatic respond(input string tag, input logic [31:0] rd, input logic to_data);
        next_cycle();
        m_data_ok = 1'b1;
        m_rdata   = rd;
        @(negedge clk);
        check({tag, "_data_ok"}, {31'd0, data_data_ok}, {31'd0, to_data});
        check({tag, "_inst_ok"}, {31'd0, inst_data_ok}, {31'd0, ~to_data});
        check({tag, "_rdata"}, to_data ? data_rdata : inst_rdata, rd);
    endtask

    initial begin
        resetn     = 1'b0;
        inst_req   = 1'b0;  inst_wr = 1'b0;  inst_size = 2'd2;  inst_wstrb = 4'hf;
        inst_addr  = '0;    inst_wdata = '0;
        data_req   = 1'b1;  data_wr = 1'b0;  data_size = 2'd2;  data_wstrb = 4'hf;
        data_addr  = 32'h0000_0a00;  data_wdata = '0;
        m_addr_ok  = 1'b1;  m_data_ok = 1'b0;  m_rdata = '0;

        // Reset: outputs held low even with a live request.
        #12;
        check("rst_m_req", {31'd0, m_req}, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_cnt", {29'd0, outst_cnt}, 32'd0);
        check("rst_perr", {31'd0, proto_err}, 32'd0);
        data_req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Test 1: simultaneous requests, data wins, inst next cycle.
        next_cycle();
        data_req = 1'b1;  data_addr = 32'h0000_0a00;
        inst_req = 1'b1;  inst_addr = 32'h0000_0b00;
        m_addr_ok = 1'b1;
        @(negedge clk);
        check("t1_m_addr", m_addr, 32'h0000_0a00);
        check("t1_d_aok", {31'd0, data_addr_ok}, 32'd1);
        check("t1_i_aok", {31'd0, inst_addr_ok}, 32'd0);
        next_cycle();
        data_req = 1'b0;
        @(negedge clk);
        check("t1_m_addr2", m_addr, 32'h0000_0b00);
        check("t1_i_aok2", {31'd0, inst_addr_ok}, 32'd1);
        next_cycle();
        inst_req = 1'b0;  m_addr_ok = 1'b0;
        @(negedge clk);
        check("t1_cnt", {29'd0, outst_cnt}, 32'd2);
        respond("t1_r0", 32'hd00d_0001, 1'b1);
        respond("t1_r1", 32'h1001_0002, 1'b0);

        // Test 2: inst locked for three cycles, data waits.
        next_cycle();
        m_data_ok = 1'b0;
        inst_req = 1'b1;  inst_addr = 32'h0000_0c00;  m_addr_ok = 1'b0;
        @(negedge clk);
        check("t2_c1_addr", m_addr, 32'h0000_0c00);
        check("t2_c1_iaok", {31'd0, inst_addr_ok}, 32'd0);
        next_cycle();
        data_req = 1'b1;  data_addr = 32'h0000_0d00;
        @(negedge clk);
        check("t2_c2_addr", m_addr, 32'h0000_0c00);
        check("t2_c2_daok", {31'd0, data_addr_ok}, 32'd0);
        next_cycle();
        m_addr_ok = 1'b1;
        @(negedge clk);
        check("t2_c3_addr", m_addr, 32'h0000_0c00);
        check("t2_c3_iaok", {31'd0, inst_addr_ok}, 32'd1);
        check("t2_c3_daok", {31'd0, data_addr_ok}, 32'd0);
        next_cycle();
        inst_req = 1'b0;
        @(negedge clk);
        check("t2_c4_addr", m_addr, 32'h0000_0d00);
        check("t2_c4_daok", {31'd0, data_addr_ok}, 32'd1);
        next_cycle();
        data_req = 1'b0;  m_addr_ok = 1'b0;
        @(negedge clk);
        check("t2_cnt", {29'd0, outst_cnt}, 32'd2);
        respond("t2_r0", 32'h0000_00c0, 1'b0);
        respond("t2_r1", 32'h0000_00d0, 1'b1);

        // Test 3: accept inst, data, inst; responses routed by owner.
        next_cycle();
        m_data_ok = 1'b0;  m_addr_ok = 1'b1;
        inst_req = 1'b1;  inst_addr = 32'h0000_1000;
        next_cycle();
        inst_req = 1'b0;  data_req = 1'b1;  data_addr = 32'h0000_2000;
        next_cycle();
        data_req = 1'b0;  inst_req = 1'b1;  inst_addr = 32'h0000_3000;
        next_cycle();
        inst_req = 1'b0;  m_addr_ok = 1'b0;
        @(negedge clk);
        check("t3_cnt3", {29'd0, outst_cnt}, 32'd3);
        respond("t3_r0", 32'h11, 1'b0);
        respond("t3_r1", 32'h22, 1'b1);
        respond("t3_r2", 32'h33, 1'b0);
        next_cycle();
        m_data_ok = 1'b0;
        @(negedge clk);
        check("t3_cnt0", {29'd0, outst_cnt}, 32'd0);

        // Test 4: fill to MAX_OUTST, no bypass on the popping cycle.
        next_cycle();
        data_req = 1'b1;  data_addr = 32'h0000_4000;  m_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
        end
        @(negedge clk);
        check("t4_full_mreq", {31'd0, m_req}, 32'd0);
        check("t4_full_daok", {31'd0, data_addr_ok}, 32'd0);
        check("t4_full_cnt", {29'd0, outst_cnt}, 32'd4);
        next_cycle();
        m_data_ok = 1'b1;  m_rdata = 32'h44;
        @(negedge clk);
        check("t4_n_mreq", {31'd0, m_req}, 32'd0);
        check("t4_n_dok", {31'd0, data_data_ok}, 32'd1);
        check("t4_n_cnt", {29'd0, outst_cnt}, 32'd4);
        next_cycle();
        m_data_ok = 1'b0;
        @(negedge clk);
        check("t4_n1_mreq", {31'd0, m_req}, 32'd1);
        check("t4_n1_daok", {31'd0, data_addr_ok}, 32'd1);
        next_cycle();
        data_req = 1'b0;  m_addr_ok = 1'b0;
        @(negedge clk);
        check("t4_refill_cnt", {29'd0, outst_cnt}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            respond("t4_drain", 32'h50 + i, 1'b1);
        end
        next_cycle();
        m_data_ok = 1'b0;
        @(negedge clk);
        check("t4_cnt0", {29'd0, outst_cnt}, 32'd0);

        // Test 5: stray response sets sticky error; async reset clears at once.
        next_cycle();
        m_data_ok = 1'b1;  m_rdata = 32'h99;
        @(negedge clk);
        check("t5_dok", {31'd0, data_data_ok}, 32'd0);
        check("t5_iok", {31'd0, inst_data_ok}, 32'd0);
        next_cycle();
        m_data_ok = 1'b0;
        @(negedge clk);
        check("t5_perr", {31'd0, proto_err}, 32'd1);
        next_cycle();
        data_req = 1'b1;  m_addr_ok = 1'b1;
        next_cycle();
        m_addr_ok = 1'b0;
        @(negedge clk);
        check("t5_perr_sticky", {31'd0, proto_err}, 32'd1);
        check("t5_cnt1", {29'd0, outst_cnt}, 32'd1);
        check("t5_mreq_pre", {31'd0, m_req}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("t5_rst_perr", {31'd0, proto_err}, 32'd0);
        check("t5_rst_cnt", {29'd0, outst_cnt}, 32'd0);
        check("t5_rst_mreq", {31'd0, m_req}, 32'd0);
        data_req = 1'b0;
        #10;
        resetn = 1'b1;
        #10;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like memory port between the instruction-fetch requester (IF stage) and the data requester (EXE issue / MEM `data_sram_data_ok` return path).
- Arbitrates the address phase, locks the grant until `addr_ok`, and records the owner of every accepted transaction in an in-order owner FIFO.
- Routes each `data_ok`/`rdata` back to the owning requester.
- Sits between the CPU core and the sram-like-to-AXI bridge.

Parameters:
- MAX_OUTST, 4, maximum accepted-but-unanswered transactions (owner FIFO depth, power of 2).
- CNT_W, 3, width of the outstanding counter; must be ≥ clog2(MAX_OUTST)+1.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  inst requester request
- inst_wr  in  1  inst write (normally 0)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_wstrb  in  4  byte strobes
- inst_addr  in  32  address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  inst address accepted
- inst_data_ok  out  1  inst response valid
- inst_rdata  out  32  inst read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data requester, same meaning as the inst_* inputs
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  32  data read data
- m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata  out  1/1/2/4/32/32  downstream request
- m_addr_ok  in  1  downstream address accepted
- m_data_ok  in  1  downstream response (in order)
- m_rdata  in  32  downstream read data
- outst_cnt  out  CNT_W  current outstanding count
- proto_err  out  1  sticky: m_data_ok received with owner FIFO empty

Behaviour:
- Reset (asynchronous, resetn=0):
  - FSM goes to IDLE; FIFO pointers, outst_cnt and proto_err clear to 0.
  - All outputs are 0 while in reset; m_* request fields are 0.
  - Reset mid-transaction drops all owner records. Responses already in flight downstream are not tracked and count as proto_err after reset releases; the bridge is reset together with this block.
- FSM states: IDLE, LOCK_D, LOCK_I.
  - IDLE: if full, no grant and m_req=0. Otherwise data_req has priority over inst_req. The winner drives m_* combinationally in the same cycle.
    - Winner data and m_addr_ok=1: accept, stay IDLE.
    - Winner data and m_addr_ok=0: go to LOCK_D.
    - Same for inst, going to LOCK_I.
  - LOCK_x: m_* stays driven from requester x regardless of the other requester.
    - m_addr_ok=1: accept, return to IDLE.
    - x deasserts req (protocol violation): m_req=0, return to IDLE.
- full = (outst_cnt == MAX_OUTST), evaluated on the registered count. There is no bypass: a pop in the same cycle does not allow a push while full. In LOCK_x with full, m_req is held 0 and the state stays LOCK_x.
- Accept (m_req & m_addr_ok):
  - Pulse x_addr_ok for one cycle.
  - Push owner bit (1=data) into the FIFO.
  - The non-granted requester's addr_ok stays 0.
- Response:
  - When m_data_ok=1 and the FIFO is non-empty: pop the head. Head=1 drives data_data_ok=1, otherwise inst_data_ok=1.
  - rdata is m_rdata for both requesters, qualified by its data_ok.
  - When the FIFO is empty: no data_ok is issued and proto_err is set.
- Latency:
  - addr_ok is combinational, zero cycles.
  - data_ok is a combinational pass-through of m_data_ok.
  - The arbiter adds no cycles.
- Simultaneous push and pop: outst_cnt stays unchanged, and both pointers advance modulo MAX_OUTST.
- Pointer wrap: pointers are clog2(MAX_OUTST) bits and count is kept separately, so a full and an empty FIFO with equal pointers are distinguished by count.
- Writes: owner is recorded the same way. The write's data_ok is routed like a read; rdata is don't-care.

Decomposition:
- Shared header `head.h`:
  - size encodings: SIZE_B=0, SIZE_H=1, SIZE_W=2.
  - owner encodings: OWN_INST=0, OWN_DATA=1.
  - state encodings: IDLE, LOCK_D, LOCK_I.
- One sub-module: owner_fifo (1-bit wide, depth MAX_OUTST). Ports: push, pop, din, dout, count, full, empty. Pointers and count are reset asynchronously.

Test Plan:
- Test 1, same-cycle request with addr_ok:
  - Stimulus: inst_req=1 and data_req=1 in the same cycle, with m_addr_ok=1.
  - Required: m_addr=data_addr, data_addr_ok=1, inst_addr_ok=0.
  - Then in the next cycle: inst is granted and outst_cnt=2.
- Test 2, grant lock:
  - Stimulus: inst_req with m_addr_ok=0 for 3 cycles. data_req rises in cycle 2. m_addr_ok=1 in cycle 3.
  - Required: m_addr stays inst_addr for all 3 cycles, inst_addr_ok pulses in cycle 3, and data is granted in cycle 4.
- Test 3, out-of-order mix:
  - Stimulus: accept in order inst, data, inst. Return m_data_ok with rdata 0x11, 0x22, 0x33.
  - Required: inst_rdata=0x11, data_rdata=0x22, inst_rdata=0x33, and outst_cnt returns to 0.
- Test 4, full:
  - Stimulus: accept 4 transactions with no response.
  - Required: m_req=0 while data_req=1.
  - Then m_data_ok in cycle N: still no grant in N. Grant in N+1, and outst_cnt stays at 4 throughout.
- Test 5, error and reset:
  - Stimulus: m_data_ok=1 with the FIFO empty.
  - Required: proto_err=1 (sticky) and no x_data_ok.
  - Then assert resetn=0 asynchronously mid-cycle: proto_err, outst_cnt and m_req go to 0 immediately.
